// File: rtl/clk_rst_sequencer.sv
// Staged power-on/software reset sequencer with a runtime-programmable 50% duty divided clock.
// Reset stages release in ascending order; the divider runs independently of the software reset.
module clk_rst_sequencer #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned HOLD_CYCLES = 100,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned DIV_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [DIV_WIDTH-1:0]  div_val,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  seq_done,
  output logic                  clk_div_out,
  output logic                  clk_div_en
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [HOLD_W-1:0]     HOLD_LAST    = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST     = GAP_W'(STAGE_GAP - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE    = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] ALL_RELEASED = '1;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_e;

  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
  logic                  clk_div_q, clk_div_d;
  logic                  clk_div_en_q, clk_div_en_d;
  logic [NUM_STAGES-1:0] rst_n_shift;

  // Shifting a 1 in from the bottom releases the next-higher stage and never re-asserts a lower one.
  assign rst_n_shift = (rst_n_q << 1) | STAGE_ONE;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rst_n_d    = rst_n_q;
    done_d     = done_q;

    if (sw_rst_req) begin
      state_d    = HOLD;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      rst_n_d    = '0;
      done_d     = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            rst_n_d    = rst_n_shift;
            if (rst_n_shift == ALL_RELEASED) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            rst_n_d   = rst_n_shift;
            if (rst_n_shift == ALL_RELEASED) begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        RUN: begin
        end
        default: state_d = HOLD;
      endcase
    end
  end

  // Divisor is re-latched only on a toggle so a mid-period change cannot shorten the current half.
  always_comb begin
    div_cnt_d    = div_cnt_q + 1'b1;
    div_lat_d    = div_lat_q;
    clk_div_d    = clk_div_q;
    clk_div_en_d = 1'b0;
    if (div_cnt_q == div_lat_q) begin
      div_cnt_d    = '0;
      div_lat_d    = div_val;
      clk_div_d    = ~clk_div_q;
      clk_div_en_d = ~clk_div_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOLD;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      rst_n_q      <= '0;
      done_q       <= 1'b0;
      div_cnt_q    <= '0;
      div_lat_q    <= div_val;
      clk_div_q    <= 1'b0;
      clk_div_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      rst_n_q      <= rst_n_d;
      done_q       <= done_d;
      div_cnt_q    <= div_cnt_d;
      div_lat_q    <= div_lat_d;
      clk_div_q    <= clk_div_d;
      clk_div_en_q <= clk_div_en_d;
    end
  end

  assign rst_n_out   = rst_n_q;
  assign seq_done    = done_q;
  assign clk_div_out = clk_div_q;
  assign clk_div_en  = clk_div_en_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer: staged release timing, software re-run, divider behaviour.
// A second instance covers the single-stage, one-cycle-hold configuration.
module tb_clk_rst_sequencer;

  localparam int LAST_E     = 132;
  localparam int DIV3_PER   = 8;
  localparam int N_VEC      = 7;

  typedef struct {
    int         edge_num;
    logic [2:0] rst_n;
    logic       done;
  } seq_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst_req;
  logic [7:0] div_val;
  logic [2:0] rst_n_out;
  logic       seq_done;
  logic       clk_div_out;
  logic       clk_div_en;
  logic [0:0] rst_n2;
  logic       done2;
  logic       div2;
  logic       en2;

  int checks   = 0;
  int failures = 0;

  seq_vec_t seq_tbl [N_VEC];

  logic mon_en = 1'b0;
  logic prev_out = 1'b0;
  int   cyc = 0;
  int   last_rise = -1;
  int   rises = 0;
  int   period_errs = 0;
  int   en_errs = 0;

  clk_rst_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(100), .STAGE_GAP(16), .DIV_WIDTH(8)
  ) u_dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .div_val(div_val),
    .rst_n_out(rst_n_out), .seq_done(seq_done),
    .clk_div_out(clk_div_out), .clk_div_en(clk_div_en)
  );

  clk_rst_sequencer #(
    .NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(16), .DIV_WIDTH(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .div_val(div_val),
    .rst_n_out(rst_n2), .seq_done(done2),
    .clk_div_out(div2), .clk_div_en(en2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Divider monitor: period of clk_div_out and alignment of clk_div_en with its rising edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (clk_div_en !== (clk_div_out & ~prev_out)) en_errs++;
      if (!mon_en) last_rise = -1;
      if (mon_en && clk_div_out === 1'b1 && prev_out === 1'b0) begin
        rises++;
        if (last_rise >= 0 && (cyc - last_rise) != DIV3_PER) period_errs++;
        last_rise = cyc;
      end
      prev_out = clk_div_out;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk the release table; start_e edges with the reset source low have already elapsed.
  task automatic check_sequence(input string tag, input int start_e);
    int   e = start_e;
    logic stable = 1'b1;
    for (int i = 0; i < N_VEC; i++) begin
      while (e < seq_tbl[i].edge_num) begin
        step();
        e++;
        if (e > LAST_E && (rst_n_out !== 3'b111 || seq_done !== 1'b1)) stable = 1'b0;
      end
      check($sformatf("%s_rst_n@%0d", tag, e), 32'(rst_n_out), 32'(seq_tbl[i].rst_n));
      check($sformatf("%s_done@%0d", tag, e), 32'(seq_done), 32'(seq_tbl[i].done));
    end
    check($sformatf("%s_stable", tag), 32'(stable), 32'd1);
  endtask

  task automatic measure(output int hi, output int lo, output int hits,
                         output logic aligned, output logic ok);
    int g = 0;
    hi = 0; lo = 0; hits = 0; aligned = 1'b0;
    while (clk_div_out !== 1'b0 && g < 64) begin step(); g++; end
    while (clk_div_out !== 1'b1 && g < 64) begin step(); g++; end
    aligned = clk_div_en;
    while (clk_div_out === 1'b1 && g < 64) begin hi++; hits += int'(clk_div_en); step(); g++; end
    while (clk_div_out === 1'b0 && g < 64) begin lo++; hits += int'(clk_div_en); step(); g++; end
    ok = (g < 64);
  endtask

  initial begin
    int   e;
    int   r0;
    int   hi, lo, hits, cnt, g;
    logic aligned, ok, held;

    seq_tbl[0] = '{99,  3'b000, 1'b0};
    seq_tbl[1] = '{100, 3'b001, 1'b0};
    seq_tbl[2] = '{115, 3'b001, 1'b0};
    seq_tbl[3] = '{116, 3'b011, 1'b0};
    seq_tbl[4] = '{131, 3'b011, 1'b0};
    seq_tbl[5] = '{132, 3'b111, 1'b1};
    seq_tbl[6] = '{500, 3'b111, 1'b1};

    // Power-on reset
    rst = 1'b1; sw_rst_req = 1'b0; div_val = 8'd3;
    repeat (5) step();
    check("por_rst_n", 32'(rst_n_out), 32'd0);
    check("por_done", 32'(seq_done), 32'd0);
    check("por_div", 32'(clk_div_out), 32'd0);
    check("por_en", 32'(clk_div_en), 32'd0);
    check("por_dut1_rst_n", 32'(rst_n2), 32'd0);
    check("por_dut1_done", 32'(done2), 32'd0);
    check("por_dut1_div", 32'(div2), 32'd0);

    rst = 1'b0;
    mon_en = 1'b1;
    step();
    check("dut1_rst_n@1", 32'(rst_n2), 32'd1);
    check("dut1_done@1", 32'(done2), 32'd1);
    check_sequence("por", 1);
    check("por_div_period", 32'(period_errs), 32'd0);
    check("por_div_running", 32'(rises > 40), 32'd1);

    // Software re-run from RUN, one-cycle request
    r0 = rises;
    sw_rst_req = 1'b1;
    step();
    check("sw_assert_rst_n", 32'(rst_n_out), 32'd0);
    check("sw_assert_done", 32'(seq_done), 32'd0);
    sw_rst_req = 1'b0;
    check_sequence("sw", 0);
    check("sw_div_period", 32'(period_errs), 32'd0);
    check("sw_div_running", 32'(rises > r0 + 40), 32'd1);

    // Request arrives right after stage 0 releases and is held 10 cycles
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    e = 0;
    while (e < 100) begin step(); e++; end
    check("swmid_stage0", 32'(rst_n_out), 32'b001);
    sw_rst_req = 1'b1;
    step();
    check("swmid_reassert", 32'(rst_n_out), 32'd0);
    check("swmid_done", 32'(seq_done), 32'd0);
    held = 1'b1;
    repeat (9) begin
      step();
      if (rst_n_out !== 3'b000 || seq_done !== 1'b0) held = 1'b0;
    end
    check("swmid_held", 32'(held), 32'd1);
    sw_rst_req = 1'b0;
    check_sequence("swmid", 0);
    check("swmid_div_period", 32'(period_errs), 32'd0);

    // Divider shapes
    mon_en = 1'b0;
    div_val = 8'd0;
    repeat (12) step();
    measure(hi, lo, hits, aligned, ok);
    check("div0_ok", 32'(ok), 32'd1);
    check("div0_hi", 32'(hi), 32'd1);
    check("div0_lo", 32'(lo), 32'd1);
    check("div0_en_hits", 32'(hits), 32'd1);
    check("div0_en_aligned", 32'(aligned), 32'd1);
    div_val = 8'd3;
    repeat (12) step();
    measure(hi, lo, hits, aligned, ok);
    check("div3_ok", 32'(ok), 32'd1);
    check("div3_hi", 32'(hi), 32'd4);
    check("div3_lo", 32'(lo), 32'd4);
    check("div3_en_hits", 32'(hits), 32'd1);
    check("div3_en_aligned", 32'(aligned), 32'd1);

    // Divisor change 3 -> 1 two cycles into a high half-period
    repeat (10) step();
    g = 0;
    while (clk_div_out !== 1'b0 && g < 64) begin step(); g++; end
    while (clk_div_out !== 1'b1 && g < 64) begin step(); g++; end
    cnt = 1;
    repeat (2) begin
      step();
      if (clk_div_out === 1'b1) cnt++;
    end
    div_val = 8'd1;
    step();
    while (clk_div_out === 1'b1 && g < 64) begin cnt++; step(); g++; end
    check("chg_old_half", 32'(cnt), 32'd4);
    lo = 0;
    while (clk_div_out === 1'b0 && g < 64) begin lo++; step(); g++; end
    check("chg_new_lo", 32'(lo), 32'd2);
    hi = 0;
    while (clk_div_out === 1'b1 && g < 64) begin hi++; step(); g++; end
    check("chg_new_hi", 32'(hi), 32'd2);
    check("chg_ok", 32'(g < 64), 32'd1);
    div_val = 8'd3;
    repeat (12) step();

    // rst together with sw_rst_req in the middle of RELEASE, while clk_div_out is high
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    e = 0;
    while ((e < 104 || clk_div_out !== 1'b1) && e < 200) begin step(); e++; end
    check("mid_rel_state", 32'(rst_n_out), 32'b001);
    check("mid_rel_div_high", 32'(clk_div_out), 32'd1);
    rst = 1'b1; sw_rst_req = 1'b1;
    step();
    check("rst_mid_rst_n", 32'(rst_n_out), 32'd0);
    check("rst_mid_done", 32'(seq_done), 32'd0);
    check("rst_mid_div", 32'(clk_div_out), 32'd0);
    check("rst_mid_en", 32'(clk_div_en), 32'd0);
    check("rst_mid_dut1_rst_n", 32'(rst_n2), 32'd0);
    check("rst_mid_dut1_done", 32'(done2), 32'd0);
    repeat (2) step();
    rst = 1'b0; sw_rst_req = 1'b0;
    r0 = rises;
    mon_en = 1'b1;
    step();
    check("rst_mid_dut1_rst_n@1", 32'(rst_n2), 32'd1);
    check("rst_mid_dut1_done@1", 32'(done2), 32'd1);
    check_sequence("post_rst", 1);
    check("post_rst_div_period", 32'(period_errs), 32'd0);
    check("post_rst_div_running", 32'(rises > r0 + 40), 32'd1);
    check("en_alignment_monitor", 32'(en_errs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
